// File: rtl/user_bus_arbiter_if.sv
// Single-word request/ack channel between one bus master and the arbiter.
// Master drives req/wr/addr/wdata/ceb; arbiter returns ack pulse and rdata.
interface user_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic [7:0]  ceb;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, wr, addr, wdata, ceb,
    input  ack, rdata
  );

  modport slave (
    input  req, wr, addr, wdata, ceb,
    output ack, rdata
  );
endinterface

// File: rtl/user_bus_arbiter.sv
// Round-robin arbiter sharing the external user bus between two masters.
// Ports: CK50/RESET, m0/m1 request channels, USER_* bus, GRANT, BUSY.
module user_bus_arbiter #(
  parameter int STROBE_CYCLES = 2,
  parameter int SETUP_CYCLES  = 1,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        CK50,
  input  logic        RESET,
  user_bus_arbiter_if.slave m0,
  user_bus_arbiter_if.slave m1,
  output logic [21:0] USER_ADDR,
  inout  wire  [63:0] USER_DATA,
  output logic        USER_WEb,
  output logic        USER_REb,
  output logic        USER_OEb,
  output logic [7:0]  USER_CEb,
  output logic [1:0]  GRANT,
  output logic        BUSY
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, ACK
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        last_m1;
  logic        own_m1, own_n;
  logic        pick_m1, start, in_tx;
  logic        wr_q, wr_n;
  logic [21:0] addr_q, addr_n;
  logic [7:0]  ceb_q, ceb_n;
  logic [31:0] wdata_q;
  logic        drv_q;
  logic [31:0] rd_cap;

  assign USER_DATA = drv_q ? {32'b0, wdata_q} : 'z;

  // M1 wins only if alone or if M0 was served last.
  always_comb begin
    pick_m1 = m1.req & (~m0.req | ~last_m1);
    start   = (state == IDLE) & (m0.req | m1.req);
    own_n   = start ? pick_m1 : own_m1;
    wr_n    = wr_q;
    addr_n  = addr_q;
    ceb_n   = ceb_q;
    if (start) begin
      wr_n   = pick_m1 ? m1.wr   : m0.wr;
      addr_n = pick_m1 ? m1.addr : m0.addr;
      ceb_n  = pick_m1 ? m1.ceb  : m0.ceb;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SETUP;
          cnt_n   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_n = STROBE;
          cnt_n   = STROBE_LD;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          state_n = HOLD;
          cnt_n   = HOLD_LD;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          state_n = ACK;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign in_tx = (state_n == SETUP) |
                 (state_n == STROBE) |
                 (state_n == HOLD);

  // Bus outputs are registered from next-state so they
  // change cleanly on the phase boundary edge.
  always_ff @(posedge CK50 or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last_m1   <= 1'b1;
      own_m1    <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= 22'd0;
      ceb_q     <= 8'hFF;
      wdata_q   <= 32'd0;
      drv_q     <= 1'b0;
      rd_cap    <= 32'd0;
      USER_ADDR <= 22'd0;
      USER_CEb  <= 8'hFF;
      USER_WEb  <= 1'b1;
      USER_REb  <= 1'b1;
      USER_OEb  <= 1'b1;
      GRANT     <= 2'b00;
      BUSY      <= 1'b0;
      m0.ack    <= 1'b0;
      m1.ack    <= 1'b0;
      m0.rdata  <= 32'd0;
      m1.rdata  <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (start) begin
        last_m1 <= pick_m1;
        own_m1  <= pick_m1;
        wr_q    <= wr_n;
        addr_q  <= addr_n;
        ceb_q   <= ceb_n;
        wdata_q <= pick_m1 ? m1.wdata : m0.wdata;
      end
      // Sample on the edge that ends the final strobe cycle.
      if (state == STROBE && cnt == 4'd0) begin
        rd_cap <= USER_DATA[31:0];
      end
      if (in_tx) begin
        USER_ADDR <= addr_n;
      end
      USER_CEb <= in_tx ? ceb_n : 8'hFF;
      USER_OEb <= ~(in_tx & ~wr_n);
      USER_WEb <= ~((state_n == STROBE) & wr_n);
      USER_REb <= ~((state_n == STROBE) & ~wr_n);
      drv_q    <= in_tx & wr_n;
      GRANT    <= in_tx ? {own_n, ~own_n} : 2'b00;
      BUSY     <= (state_n != IDLE);
      m0.ack   <= (state_n == ACK) & ~own_n;
      m1.ack   <= (state_n == ACK) & own_n;
      if (state_n == ACK && !wr_q) begin
        if (own_n) begin
          m1.rdata <= rd_cap;
        end else begin
          m0.rdata <= rd_cap;
        end
      end
    end
  end

endmodule
